// File: rtl/bp_fetch_2bit.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Redirects fetch when the branch resolved in EX disagrees with the prediction carried alongside it.
module bp_fetch_2bit #(
  parameter int          ENTRIES  = 32,
  parameter int          IDX_W    = $clog2(ENTRIES),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int TAG_W = 32 - IDX_W - 2;

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [1:0]       ctr_d   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];

  logic [31:0] pc_q, pc_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             res;
  logic [31:0]      ex_seq;
  logic [31:0]      actual;
  logic [31:0]      predicted;

  // Fetch-side lookup on the registered PC
  always_comb begin
    f_idx         = pc_q[IDX_W+1:2];
    f_tag         = pc_q[31:IDX_W+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_o  = f_hit && ctr_q[f_idx][1];
    pred_target_o = pred_taken_o ? tgt_q[f_idx] : pc_q + 32'd4;
  end

  // EX-side resolution against the prediction that travelled with the branch
  always_comb begin
    res          = ex_valid_i && ex_is_branch_i;
    ex_seq       = ex_pc_i + 32'd4;
    actual       = ex_taken_i ? ex_target_i : ex_seq;
    predicted    = ex_pred_taken_i ? ex_pred_target_i : ex_seq;
    mispredict_o = res && (actual != predicted);
    ex_idx       = ex_pc_i[IDX_W+1:2];
    ex_tag       = ex_pc_i[31:IDX_W+2];
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  end

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (res) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ctr_sat(ctr_q[ex_idx], ex_taken_i);
        if (ex_taken_i) begin
          tgt_d[ex_idx] = ex_target_i;
        end
      end else if (ex_taken_i) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = ex_target_i;
        ctr_d[ex_idx]   = 2'b10;
      end
    end
  end

  // A mispredict redirect wins over stall so the flush is never lost
  always_comb begin
    pc_d = pred_target_o;
    if (mispredict_o) begin
      pc_d = actual;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
    br_cnt_d = res ? br_cnt_q + 32'd1 : br_cnt_q;
    mp_cnt_d = mispredict_o ? mp_cnt_q + 32'd1 : mp_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
      valid_q  <= valid_d;
      ctr_q    <= ctr_d;
    end
  end

  // Tag and target payload are only meaningful behind a set valid bit
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign pc_o          = pc_q;
  assign branch_cnt_o  = br_cnt_q;
  assign mispred_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_bp_fetch_2bit.sv
// Directed bench for bp_fetch_2bit: sequential fetch, BTB allocation, hysteresis, aliasing,
// stall/redirect priority, PC wrap and asynchronous reset.
module tb_bp_fetch_2bit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  bp_fetch_2bit #(.ENTRIES(32), .RESET_PC(32'h0)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .stall_i          (stall_i),
    .pc_o             (pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .mispredict_o     (mispredict_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid_i       = 1'b0;
    ex_is_branch_i   = 1'b0;
    ex_pc_i          = 32'h0;
    ex_taken_i       = 1'b0;
    ex_target_i      = 32'h0;
    ex_pred_taken_i  = 1'b0;
    ex_pred_target_i = 32'h0;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic ptaken, input logic [31:0] ptgt);
    ex_valid_i       = 1'b1;
    ex_is_branch_i   = 1'b1;
    ex_pc_i          = pc;
    ex_taken_i       = taken;
    ex_target_i      = tgt;
    ex_pred_taken_i  = ptaken;
    ex_pred_target_i = ptgt;
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    stall_i = 1'b0;
    idle_ex();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h4) begin errors++; $display("FAIL reset_pred_target: got %h want %h", pred_target_o, 32'h4); end
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b want 0", mispredict_o); end
    checks++; if (branch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc_o !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_o, 32'(i * 4)); end
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL seq_pred%0d: got %b want 0", i, pred_taken_o); end
    end
    checks++; if (branch_cnt_o !== 32'h0) begin errors++; $display("FAIL seq_branch_cnt: got %0d want 0", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'h0) begin errors++; $display("FAIL seq_mispred_cnt: got %0d want 0", mispred_cnt_o); end
  endtask

  task automatic test_cold_alloc();
    drive_ex(32'h0C, 1'b1, 32'h08, 1'b0, 32'h10);
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL cold_mispredict: got %b want 1", mispredict_o); end
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h08) begin errors++; $display("FAIL cold_redirect_pc: got %h want %h", pc_o, 32'h08); end
    checks++; if (mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL cold_mispred_cnt: got %0d want 1", mispred_cnt_o); end
    checks++; if (branch_cnt_o !== 32'd1) begin errors++; $display("FAIL cold_branch_cnt: got %0d want 1", branch_cnt_o); end
    step();
    checks++; if (pc_o !== 32'h0C) begin errors++; $display("FAIL cold_pc_0c: got %h want %h", pc_o, 32'h0C); end
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL cold_hit_taken: got %b want 1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h08) begin errors++; $display("FAIL cold_hit_target: got %h want %h", pred_target_o, 32'h08); end
  endtask

  task automatic test_hysteresis();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_ex(32'h0C, 1'b1, 32'h08, 1'b1, 32'h08);
      checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL hyst_taken_mis%0d: got %b want 0", i, mispredict_o); end
      step();
    end
    idle_ex();
    checks++; if (pc_o !== 32'h0C) begin errors++; $display("FAIL hyst_stall_pc: got %h want %h", pc_o, 32'h0C); end
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL hyst_strong_t: got %b want 1", pred_taken_o); end
    drive_ex(32'h0C, 1'b0, 32'h08, 1'b0, 32'h08);
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL hyst_nt_mis: got %b want 0", mispredict_o); end
    step();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL hyst_weak_t: got %b want 1", pred_taken_o); end
    step();
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL hyst_weak_nt: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h10) begin errors++; $display("FAIL hyst_weak_nt_tgt: got %h want %h", pred_target_o, 32'h10); end
    step();
    drive_ex(32'h0C, 1'b1, 32'h08, 1'b1, 32'h08);
    step();
    idle_ex();
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL hyst_sat_nt: got %b want 0", pred_taken_o); end
    checks++; if (pc_o !== 32'h0C) begin errors++; $display("FAIL hyst_pc_held: got %h want %h", pc_o, 32'h0C); end
    checks++; if (branch_cnt_o !== 32'd7) begin errors++; $display("FAIL hyst_branch_cnt: got %0d want 7", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL hyst_mispred_cnt: got %0d want 1", mispred_cnt_o); end
  endtask

  task automatic test_stall_mispredict();
    drive_ex(32'h0C, 1'b1, 32'h08, 1'b0, 32'h10);
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL stallmis_flag: got %b want 1", mispredict_o); end
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h08) begin errors++; $display("FAIL stallmis_pc: got %h want %h", pc_o, 32'h08); end
    checks++; if (mispred_cnt_o !== 32'd2) begin errors++; $display("FAIL stallmis_cnt: got %0d want 2", mispred_cnt_o); end
  endtask

  task automatic test_alias();
    drive_ex(32'h88, 1'b0, 32'h300, 1'b1, 32'h300);
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h8C) begin errors++; $display("FAIL alias_steer_pc: got %h want %h", pc_o, 32'h8C); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL alias_miss_taken: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h90) begin errors++; $display("FAIL alias_miss_target: got %h want %h", pred_target_o, 32'h90); end
    drive_ex(32'h8C, 1'b1, 32'h40, 1'b0, 32'h90);
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL alias_replace_mis: got %b want 1", mispredict_o); end
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL alias_replace_pc: got %h want %h", pc_o, 32'h40); end
    drive_ex(32'h08, 1'b0, 32'h300, 1'b1, 32'h300);
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h0C) begin errors++; $display("FAIL alias_0c_pc: got %h want %h", pc_o, 32'h0C); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL alias_0c_evicted: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h10) begin errors++; $display("FAIL alias_0c_target: got %h want %h", pred_target_o, 32'h10); end
    drive_ex(32'h88, 1'b0, 32'h300, 1'b1, 32'h300);
    step();
    idle_ex();
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL alias_8c_taken: got %b want 1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h40) begin errors++; $display("FAIL alias_8c_target: got %h want %h", pred_target_o, 32'h40); end
    checks++; if (branch_cnt_o !== 32'd12) begin errors++; $display("FAIL alias_branch_cnt: got %0d want 12", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'd6) begin errors++; $display("FAIL alias_mispred_cnt: got %0d want 6", mispred_cnt_o); end
  endtask

  task automatic test_not_taken_cold();
    drive_ex(32'h1C, 1'b0, 32'h300, 1'b0, 32'h300);
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL ntcold_mis: got %b want 0", mispredict_o); end
    step();
    idle_ex();
    checks++; if (branch_cnt_o !== 32'd13) begin errors++; $display("FAIL ntcold_branch_cnt: got %0d want 13", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'd6) begin errors++; $display("FAIL ntcold_mispred_cnt: got %0d want 6", mispred_cnt_o); end
    drive_ex(32'h1C, 1'b1, 32'h300, 1'b0, 32'h300);
    ex_is_branch_i = 1'b0;
    #1;
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL nonbranch_mis: got %b want 0", mispredict_o); end
    step();
    idle_ex();
    checks++; if (branch_cnt_o !== 32'd13) begin errors++; $display("FAIL nonbranch_cnt: got %0d want 13", branch_cnt_o); end
    drive_ex(32'h18, 1'b0, 32'h300, 1'b1, 32'h300);
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h1C) begin errors++; $display("FAIL ntcold_pc: got %h want %h", pc_o, 32'h1C); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL ntcold_no_alloc: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h20) begin errors++; $display("FAIL ntcold_target: got %h want %h", pred_target_o, 32'h20); end
  endtask

  task automatic test_wrap();
    drive_ex(32'hFFFF_FFF8, 1'b0, 32'h300, 1'b1, 32'h0);
    step();
    idle_ex();
    checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc_o, 32'hFFFF_FFFC); end
    checks++; if (pred_target_o !== 32'h0) begin errors++; $display("FAIL wrap_pred_target: got %h want %h", pred_target_o, 32'h0); end
    drive_ex(32'hFFFF_FFFC, 1'b0, 32'h300, 1'b1, 32'h0);
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL wrap_ex_mis: got %b want 0", mispredict_o); end
    idle_ex();
    stall_i = 1'b0;
    step();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h want %h", pc_o, 32'h0); end
    checks++; if (mispred_cnt_o !== 32'd8) begin errors++; $display("FAIL wrap_mispred_cnt: got %0d want 8", mispred_cnt_o); end
  endtask

  task automatic test_reset_mid();
    drive_ex(32'h04, 1'b1, 32'h40, 1'b1, 32'h40);
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL rmid_alloc_mis: got %b want 0", mispredict_o); end
    step();
    idle_ex();
    checks++; if (pc_o !== 32'h04) begin errors++; $display("FAIL rmid_pc4: got %h want %h", pc_o, 32'h04); end
    checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL rmid_hit_before: got %b want 1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h40) begin errors++; $display("FAIL rmid_tgt_before: got %h want %h", pred_target_o, 32'h40); end
    rst_ni = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rmid_async_pc: got %h want %h", pc_o, 32'h0); end
    checks++; if (branch_cnt_o !== 32'h0) begin errors++; $display("FAIL rmid_branch_cnt: got %0d want 0", branch_cnt_o); end
    checks++; if (mispred_cnt_o !== 32'h0) begin errors++; $display("FAIL rmid_mispred_cnt: got %0d want 0", mispred_cnt_o); end
    drive_ex(32'h04, 1'b1, 32'h40, 1'b1, 32'h40);
    step();
    idle_ex();
    rst_ni = 1'b1;
    step();
    checks++; if (pc_o !== 32'h04) begin errors++; $display("FAIL rmid_after_pc: got %h want %h", pc_o, 32'h04); end
    checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL rmid_btb_cleared: got %b want 0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h08) begin errors++; $display("FAIL rmid_after_tgt: got %h want %h", pred_target_o, 32'h08); end
    checks++; if (branch_cnt_o !== 32'h0) begin errors++; $display("FAIL rmid_after_cnt: got %0d want 0", branch_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_cold_alloc();
    test_hysteresis();
    test_stall_mispredict();
    test_alias();
    test_not_taken_cold();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
